// File: rtl/mips_pkg.sv
// Shared constants and state encoding for the MIPS divide unit.
package mips_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_sub_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, trial-subtract, select.
module div_sub_step
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           ge;

  // The shifted remainder is below 2*divisor, so bit WIDTH of the difference is a clean borrow.
  always_comb begin
    rem_sh = {rem_i, quo_i[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_i};
    ge     = ~diff[WIDTH];
    rem_o  = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_o  = {quo_i[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mips_div_unit.sv
// Iterative restoring divider for DIV/DIVU; quotient feeds LO, remainder feeds HI.
module mips_div_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic             cancel,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] dvd_abs_c;
  logic [WIDTH-1:0] dvs_abs_c;
  logic [WIDTH-1:0] step_rem_c;
  logic [WIDTH-1:0] step_quo_c;

  div_sub_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem_c),
    .quo_o (step_quo_c)
  );

  // Operand magnitudes; the most negative value maps onto itself, which is correct as unsigned.
  always_comb begin
    dvd_abs_c = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs_c = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  end

  // Next-state, datapath and output logic; cancel outranks start everywhere.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvs_d         = dvs_q;
    dvd_d         = dvd_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dbz_d         = dbz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !cancel) begin
          state_d = CALC;
          count_d = '0;
          rem_d   = '0;
          quo_d   = dvd_abs_c;
          dvs_d   = dvs_abs_c;
          dvd_d   = dividend;
          q_neg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_neg_d = is_signed & dividend[WIDTH-1];
          dbz_d   = (divisor == '0);
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d   = step_rem_c;
          quo_d   = step_quo_c;
          count_d = CNT_W'(count_q + 1'b1);
          if (count_q == CNT_W'(WIDTH - 1)) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          state_d       = DONE;
          div_by_zero_d = dbz_q;
          if (dbz_q) begin
            quotient_d  = '1;
            remainder_d = dvd_q;
          end else begin
            quotient_d  = q_neg_q ? -quo_q : quo_q;
            remainder_d = r_neg_q ? -rem_q : rem_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CALC) || (state_d == FIX);
    done_d = (state_d == DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      count_q       <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvs_q         <= '0;
      dvd_q         <= '0;
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dbz_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvs_q         <= dvs_d;
      dvd_q         <= dvd_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dbz_q         <= dbz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mips_div_unit.sv
// Self-checking bench for mips_div_unit: directed corner cases, random ops, handshake, cancel, reset.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] last_q;
  logic [31:0] last_r;
  logic        last_z;

  mips_div_unit #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .is_signed   (is_signed),
    .cancel      (cancel),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: MIPS semantics via 64-bit truncating division, plus the divide-by-zero rule.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint na, nb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      if (sgn) begin
        na = longint'($signed(a));
        nb = longint'($signed(b));
      end else begin
        na = longint'({32'd0, a});
        nb = longint'({32'd0, b});
      end
      q = 32'(na / nb);
      r = 32'(na % nb);
      z = 1'b0;
    end
  endfunction

  // Present operands with start for one edge, then scramble operands to prove they were captured.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    dividend  = a;
    divisor   = b;
    is_signed = sgn;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  // Wait (bounded) for done; n=0 on timeout, bcnt counts cycles with busy high.
  task automatic wait_done(input int budget, output int n, output int bcnt);
    n    = 0;
    bcnt = 0;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (busy) bcnt++;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; cancel = 1'b0; is_signed = 1'b0;
    dividend = 32'd0; divisor = 32'd0;
    #12;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quotient: got %h expected 0", quotient); end
    n_checks++; if (remainder !== 32'd0) begin n_fail++; $display("FAIL reset_remainder: got %h expected 0", remainder); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [7] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    logic [31:0] tb [7] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    bit          ts [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] eq [7] = '{32'd14, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] er [7] = '{32'd2, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
    logic        ez [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int n, bc, b0;
    for (int k = 0; k < 7; k++) begin
      issue(ta[k], tb[k], ts[k]);
      b0 = busy ? 1 : 0;
      wait_done(40, n, bc);
      n_checks++; if (n !== 33) begin n_fail++; $display("FAIL dir%0d_latency: got %0d expected 33", k, n); end
      n_checks++; if (bc + b0 !== 33) begin n_fail++; $display("FAIL dir%0d_busy_cycles: got %0d expected 33", k, bc + b0); end
      n_checks++; if (quotient !== eq[k]) begin n_fail++; $display("FAIL dir%0d_quotient: got %h expected %h", k, quotient, eq[k]); end
      n_checks++; if (remainder !== er[k]) begin n_fail++; $display("FAIL dir%0d_remainder: got %h expected %h", k, remainder, er[k]); end
      n_checks++; if (div_by_zero !== ez[k]) begin n_fail++; $display("FAIL dir%0d_dbz: got %b expected %b", k, div_by_zero, ez[k]); end
      @(posedge clk);
      #1;
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL dir%0d_done_pulse: got %b expected 0", k, done); end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, q, r;
    logic        z;
    bit          sgn;
    int          n, bc;
    for (int k = 0; k < 24; k++) begin
      a = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = 32'hFFFF_FFFF;
        3:       b = $urandom >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      if (b == 32'd0 && $urandom_range(0, 1) == 1) b = 32'd3;
      sgn = 1'($urandom_range(0, 1));
      ref_div(a, b, sgn, q, r, z);
      issue(a, b, sgn);
      wait_done(40, n, bc);
      n_checks++; if (n !== 33) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d expected 33", k, n); end
      n_checks++; if (quotient !== q || remainder !== r || div_by_zero !== z) begin
        n_fail++;
        $display("FAIL rnd%0d_result a=%h b=%h s=%0d: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                 k, a, b, sgn, quotient, remainder, div_by_zero, q, r, z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q, r;
    logic        z;
    int          n, bc, got;
    issue(32'd100, 32'd7, 1'b0);
    got = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        got = i;
        break;
      end
      if (i == 9) begin
        start     = 1'b1;
        dividend  = 32'd55;
        divisor   = 32'd3;
        is_signed = 1'b1;
      end
    end
    n_checks++; if (got !== 33) begin n_fail++; $display("FAIL b2b_first_latency: got %0d expected 33", got); end
    n_checks++; if (quotient !== 32'd14 || remainder !== 32'd2) begin
      n_fail++; $display("FAIL b2b_ignored_start: got q=%h r=%h expected q=0000000e r=00000002", quotient, remainder);
    end
    ref_div(32'hFFFF_FFF7, 32'd4, 1'b1, q, r, z);
    issue(32'hFFFF_FFF7, 32'd4, 1'b1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%b expected 1", busy); end
    wait_done(40, n, bc);
    n_checks++; if (n !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 33", n); end
    n_checks++; if (quotient !== q || remainder !== r || div_by_zero !== z) begin
      n_fail++; $display("FAIL b2b_second_result: got q=%h r=%h expected q=%h r=%h", quotient, remainder, q, r);
    end
    last_q = q;
    last_r = r;
    last_z = z;
  endtask

  task automatic test_cancel();
    bit seen;
    issue(32'd1000, 32'd3, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b expected 0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL cancel_no_done: got %b expected 0", seen); end
    n_checks++; if (quotient !== last_q || remainder !== last_r || div_by_zero !== last_z) begin
      n_fail++; $display("FAIL cancel_hold: got q=%h r=%h z=%b expected q=%h r=%h z=%b",
                         quotient, remainder, div_by_zero, last_q, last_r, last_z);
    end
  endtask

  task automatic test_reset_mid();
    int n, bc;
    issue(32'd12345, 32'd6, 1'b0);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (quotient !== 32'd0 || remainder !== 32'd0 || div_by_zero !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_outputs: got q=%h r=%h z=%b d=%b expected all 0", quotient, remainder, div_by_zero, done);
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(32'd81, 32'd9, 1'b0);
    wait_done(40, n, bc);
    n_checks++; if (n !== 33 || quotient !== 32'd9 || remainder !== 32'd0) begin
      n_fail++; $display("FAIL rst_recover: got n=%0d q=%h r=%h expected n=33 q=00000009 r=00000000", n, quotient, remainder);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_cancel();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
